pwm_cfg_ctrl: RTL and testbench

Register controller between the SPI slave's received-byte stream and the PWM generators. Parses framed write commands from `spi_slave` (`rx_byte`/`rx_valid`) into per-channel staging registers for compare values and the channel-enable mask. Transfers staging to the active outputs only at a PWM period boundary, so duty-cycle updates never glitch mid-period. Sits in `top` alongside `spi_slave` and drives the PWM channel inputs.

---
 rtl/pwm_cfg_ctrl.sv | 171 +++++++++++++++++
 tb/tb_pwm_cfg_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_cfg_ctrl.sv
// Parses framed SPI write commands into staging registers and commits them to the
// PWM outputs on period boundaries. Optional checksum byte: define PWM_CFG_CHKSUM_EN.
module pwm_cfg_ctrl #(
   parameter int unsigned       NUM_CH     = 4,
   parameter int unsigned       CMP_W      = 16,
   parameter logic [CMP_W-1:0]  PERIOD_MAX = 16'd62500
) (
   input  logic                     CLK,
   input  logic                     rst_n,
   input  logic [7:0]               rx_byte,
   input  logic                     rx_valid,
   input  logic                     cs_n,
   input  logic                     period_tick,
   output logic [NUM_CH*CMP_W-1:0]  cmp,
   output logic [NUM_CH-1:0]        ch_en,
   output logic                     pending,
   output logic                     frame_err,
   output logic [7:0]               err_cnt
);

   localparam logic [5:0] EN_ADDR  = 6'h20;
   localparam logic [5:0] NUM_CH_A = 6'(NUM_CH);

`ifdef PWM_CFG_CHKSUM_EN
   typedef enum logic [1:0] {S_IDLE, S_DHI, S_DLO, S_CHK} state_t;
   logic [7:0] cmd_q;
   logic [7:0] dlo_q;
`else
   typedef enum logic [1:0] {S_IDLE, S_DHI, S_DLO} state_t;
`endif

   state_t                    state, state_n;
   logic [5:0]                addr_q;
   logic [7:0]                dhi_q;
   logic [NUM_CH*CMP_W-1:0]   stg_cmp;
   logic [NUM_CH-1:0]         stg_en;
   logic [NUM_CH*CMP_W-1:0]   cmp_q;
   logic [NUM_CH-1:0]         en_q;
   logic [CMP_W-1:0]          wr_data;
   logic                      addr_ok;
   logic                      wr;
   logic                      err;

   function automatic logic [CMP_W-1:0] sat_cmp(input logic [CMP_W-1:0] v);
      return (v > PERIOD_MAX) ? PERIOD_MAX : v;
   endfunction

   assign addr_ok = (addr_q < NUM_CH_A) || (addr_q == EN_ADDR);
`ifdef PWM_CFG_CHKSUM_EN
   assign wr_data = {dhi_q, dlo_q};
`else
   assign wr_data = {dhi_q, rx_byte};
`endif

   // The final byte completes its frame even if cs_n rises in the same cycle.
   always_comb begin
      state_n = state;
      wr      = 1'b0;
      err     = 1'b0;
      case (state)
         S_IDLE: begin
            if (rx_valid && !cs_n) begin
               if (rx_byte[6])      err     = 1'b1;
               else if (rx_byte[7]) state_n = S_DHI;
            end
         end
         S_DHI: begin
            if (cs_n) begin
               err     = 1'b1;
               state_n = S_IDLE;
            end else if (rx_valid) begin
               state_n = S_DLO;
            end
         end
`ifdef PWM_CFG_CHKSUM_EN
         S_DLO: begin
            if (cs_n) begin
               err     = 1'b1;
               state_n = S_IDLE;
            end else if (rx_valid) begin
               state_n = S_CHK;
            end
         end
         S_CHK: begin
            if (rx_valid) begin
               state_n = S_IDLE;
               if (addr_ok && (rx_byte == (cmd_q ^ dhi_q ^ dlo_q))) wr  = 1'b1;
               else                                                 err = 1'b1;
            end else if (cs_n) begin
               err     = 1'b1;
               state_n = S_IDLE;
            end
         end
`else
         S_DLO: begin
            if (rx_valid) begin
               state_n = S_IDLE;
               if (addr_ok) wr  = 1'b1;
               else         err = 1'b1;
            end else if (cs_n) begin
               err     = 1'b1;
               state_n = S_IDLE;
            end
         end
`endif
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         addr_q    <= '0;
         dhi_q     <= '0;
`ifdef PWM_CFG_CHKSUM_EN
         cmd_q     <= '0;
         dlo_q     <= '0;
`endif
         stg_cmp   <= '0;
         stg_en    <= '0;
         cmp_q     <= '0;
         en_q      <= '0;
         pending   <= 1'b0;
         frame_err <= 1'b0;
         err_cnt   <= '0;
      end else begin
         state     <= state_n;
         frame_err <= err;
         if (err && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;

         if (rx_valid && !cs_n) begin
            case (state)
               S_IDLE: begin
                  addr_q <= rx_byte[5:0];
`ifdef PWM_CFG_CHKSUM_EN
                  cmd_q  <= rx_byte;
`endif
               end
               S_DHI: dhi_q <= rx_byte;
`ifdef PWM_CFG_CHKSUM_EN
               S_DLO: dlo_q <= rx_byte;
`endif
               default: ;
            endcase
         end

         // Commit reads pre-write staging, so a coincident write waits for the next tick.
         if (period_tick) begin
            cmp_q <= stg_cmp;
            en_q  <= stg_en;
         end

         if (wr) begin
            if (addr_q == EN_ADDR) begin
               stg_en <= wr_data[NUM_CH-1:0];
            end else begin
               for (int i = 0; i < int'(NUM_CH); i++) begin
                  if (addr_q == 6'(i)) stg_cmp[i*CMP_W +: CMP_W] <= sat_cmp(wr_data);
               end
            end
         end

         if (wr)               pending <= 1'b1;
         else if (period_tick) pending <= 1'b0;
      end
   end

   assign cmp   = cmp_q;
   assign ch_en = en_q;

endmodule

// File: tb/tb_pwm_cfg_ctrl.sv
// Directed bench for pwm_cfg_ctrl; two instances (default and PERIOD_MAX=1000).
module tb_pwm_cfg_ctrl;

   logic        CLK = 1'b0;
   logic        rst_n;
   logic [7:0]  rx_byte;
   logic        rx_valid;
   logic        cs_n;
   logic        period_tick;

   logic [63:0] cmp_a, cmp_b;
   logic [3:0]  ch_en_a, ch_en_b;
   logic        pending_a, pending_b;
   logic        frame_err_a, frame_err_b;
   logic [7:0]  err_cnt_a, err_cnt_b;

   int total = 0;
   int bad   = 0;

   always #5 CLK = ~CLK;

   pwm_cfg_ctrl #(.NUM_CH(4), .CMP_W(16), .PERIOD_MAX(16'd62500)) dut_a (
      .CLK(CLK), .rst_n(rst_n), .rx_byte(rx_byte), .rx_valid(rx_valid), .cs_n(cs_n),
      .period_tick(period_tick), .cmp(cmp_a), .ch_en(ch_en_a), .pending(pending_a),
      .frame_err(frame_err_a), .err_cnt(err_cnt_a)
   );

   pwm_cfg_ctrl #(.NUM_CH(4), .CMP_W(16), .PERIOD_MAX(16'd1000)) dut_b (
      .CLK(CLK), .rst_n(rst_n), .rx_byte(rx_byte), .rx_valid(rx_valid), .cs_n(cs_n),
      .period_tick(period_tick), .cmp(cmp_b), .ch_en(ch_en_b), .pending(pending_b),
      .frame_err(frame_err_b), .err_cnt(err_cnt_b)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic tick, input logic csn_hi);
      @(negedge CLK);
      rx_byte     = b;
      rx_valid    = 1'b1;
      period_tick = tick;
      if (csn_hi) cs_n = 1'b1;
      @(negedge CLK);
      rx_valid    = 1'b0;
      period_tick = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] c, input logic [7:0] h, input logic [7:0] l,
                             input logic tick_last, input logic csn_last);
      send_byte(c, 1'b0, 1'b0);
      send_byte(h, 1'b0, 1'b0);
`ifdef PWM_CFG_CHKSUM_EN
      send_byte(l, 1'b0, 1'b0);
      send_byte(c ^ h ^ l, tick_last, csn_last);
`else
      send_byte(l, tick_last, csn_last);
`endif
   endtask

   task automatic tick();
      @(negedge CLK);
      period_tick = 1'b1;
      @(negedge CLK);
      period_tick = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; rx_byte = 8'h00; rx_valid = 1'b0; cs_n = 1'b1; period_tick = 1'b0;
      repeat (3) @(negedge CLK);
      check("rst_cmp", cmp_a, 64'h0);
      check("rst_ch_en", {60'h0, ch_en_a}, 64'h0);
      check("rst_pending", {63'h0, pending_a}, 64'h0);
      check("rst_frame_err", {63'h0, frame_err_a}, 64'h0);
      check("rst_err_cnt", {56'h0, err_cnt_a}, 64'h0);
      rst_n = 1'b1;
      @(negedge CLK);
      cs_n = 1'b0;

      // Basic write of channel 1, commit on tick
      send_frame(8'h81, 8'h12, 8'h34, 1'b0, 1'b0);
      check("wr1_pending", {63'h0, pending_a}, 64'h1);
      check("wr1_cmp_before_tick", cmp_a, 64'h0);
      check("wr1_no_err", {63'h0, frame_err_a}, 64'h0);
      tick();
      check("wr1_cmp", cmp_a, 64'h0000_0000_1234_0000);
      check("wr1_pending_clr", {63'h0, pending_a}, 64'h0);
      check("wr1_cmp_clamp_b", cmp_b, 64'h0000_0000_03E8_0000);

      // Clamp of 0xFFFF on channel 0
      send_frame(8'h80, 8'hFF, 8'hFF, 1'b0, 1'b0);
      tick();
      check("clamp_a", cmp_a, 64'h0000_0000_1234_F424);
      check("clamp_b", cmp_b, 64'h0000_0000_03E8_03E8);

      // Abort by cs_n rise mid-frame
      send_byte(8'h80, 1'b0, 1'b0);
      send_byte(8'h00, 1'b0, 1'b0);
      cs_n = 1'b1;
      @(negedge CLK);
      check("abort_err", {63'h0, frame_err_a}, 64'h1);
      check("abort_cnt", {56'h0, err_cnt_a}, 64'h1);
      check("abort_no_pending", {63'h0, pending_a}, 64'h0);
      @(negedge CLK);
      check("abort_err_pulse", {63'h0, frame_err_a}, 64'h0);
      tick();
      check("abort_cmp_same", cmp_a, 64'h0000_0000_1234_F424);
      cs_n = 1'b0;
      send_frame(8'h82, 8'h00, 8'h10, 1'b0, 1'b0);
      check("after_abort_pending", {63'h0, pending_a}, 64'h1);
      tick();
      check("after_abort_cmp", cmp_a, 64'h0000_0010_1234_F424);

      // Enable write coincident with a tick
      send_frame(8'hA0, 8'h00, 8'h05, 1'b1, 1'b0);
      check("en_coinc_ch_en", {60'h0, ch_en_a}, 64'h0);
      check("en_coinc_pending", {63'h0, pending_a}, 64'h1);
      tick();
      check("en_ch_en", {60'h0, ch_en_a}, 64'h5);
      check("en_pending_clr", {63'h0, pending_a}, 64'h0);

      // Illegal address and reserved bit
      send_frame(8'h90, 8'h00, 8'h00, 1'b0, 1'b0);
      check("illegal_addr_err", {63'h0, frame_err_a}, 64'h1);
      check("illegal_addr_cnt", {56'h0, err_cnt_a}, 64'h2);
      send_byte(8'hC0, 1'b0, 1'b0);
      check("reserved_err", {63'h0, frame_err_a}, 64'h1);
      check("reserved_cnt", {56'h0, err_cnt_a}, 64'h3);
      check("errs_no_pending", {63'h0, pending_a}, 64'h0);

      // NOP byte followed by a normal frame
      send_byte(8'h00, 1'b0, 1'b0);
      check("nop_no_err", {63'h0, frame_err_a}, 64'h0);
      send_frame(8'h83, 8'hAB, 8'hCD, 1'b0, 1'b0);
      tick();
      check("nop_then_wr", cmp_a, 64'hABCD_0010_1234_F424);

      // cs_n rising with the final byte still completes the frame
      send_frame(8'h81, 8'h00, 8'h77, 1'b0, 1'b1);
      check("csn_final_no_err", {63'h0, frame_err_a}, 64'h0);
      check("csn_final_cnt", {56'h0, err_cnt_a}, 64'h3);
      check("csn_final_pending", {63'h0, pending_a}, 64'h1);
      tick();
      check("csn_final_cmp", cmp_a, 64'hABCD_0010_0077_F424);

      // Byte while cs_n high is ignored
      send_byte(8'h81, 1'b0, 1'b0);
      cs_n = 1'b0;
      send_frame(8'h83, 8'h00, 8'h01, 1'b0, 1'b0);
      tick();
      check("csn_high_ignored", cmp_a, 64'h0001_0010_0077_F424);

      // Reset mid-frame
      send_byte(8'h81, 1'b0, 1'b0);
      send_byte(8'h55, 1'b0, 1'b0);
      rst_n = 1'b0;
      @(negedge CLK);
      check("midrst_cmp", cmp_a, 64'h0);
      check("midrst_err_cnt", {56'h0, err_cnt_a}, 64'h0);
      rst_n = 1'b1;
      @(negedge CLK);
      send_frame(8'h80, 8'h00, 8'h22, 1'b0, 1'b0);
      check("midrst_no_err", {63'h0, frame_err_a}, 64'h0);
      tick();
      check("midrst_next_frame", cmp_a, 64'h0000_0000_0000_0022);

`ifdef PWM_CFG_CHKSUM_EN
      send_byte(8'h82, 1'b0, 1'b0);
      send_byte(8'h00, 1'b0, 1'b0);
      send_byte(8'h10, 1'b0, 1'b0);
      send_byte(8'h92, 1'b0, 1'b0);
      check("chk_ok_pending", {63'h0, pending_a}, 64'h1);
      check("chk_ok_no_err", {63'h0, frame_err_a}, 64'h0);
      send_byte(8'h81, 1'b0, 1'b0);
      send_byte(8'h00, 1'b0, 1'b0);
      send_byte(8'h11, 1'b0, 1'b0);
      send_byte(8'h00, 1'b0, 1'b0);
      check("chk_bad_err", {63'h0, frame_err_a}, 64'h1);
      check("chk_bad_cnt", {56'h0, err_cnt_a}, 64'h1);
      tick();
      check("chk_cmp", cmp_a, 64'h0000_0010_0000_0022);
`endif

      // Saturating error counter
      for (int i = 0; i < 300; i++) send_byte(8'hC0, 1'b0, 1'b0);
      check("sat_err_cnt", {56'h0, err_cnt_a}, 64'hFF);
      check("sat_err_cnt_b", {56'h0, err_cnt_b}, 64'hFF);
      @(negedge CLK);
      check("sat_err_cnt_hold", {56'h0, err_cnt_a}, 64'hFF);
      check("sat_frame_err_low", {63'h0, frame_err_a}, 64'h0);
      check("final_ch_en_b", {60'h0, ch_en_b}, 64'h0);
      check("final_pending_b", {62'h0, pending_b, frame_err_b}, 64'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
